// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter.
// It drives both lines open-drain through pull-low enables and signals the
// keyboard receiver with `busy` so that the receiver ignores the bus while a
// host transfer is in progress. The clock input is synchronised and then
// glitch-filtered. Every device clock fall is detected on the filtered level.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3200,    // clock held low for request-to-send
    parameter int RTS_CYCLES     = 64,      // clock+data both low before clock release
    parameter int TIMEOUT_CYCLES = 480000,  // clock release to final idle
    parameter int FILTER_LEN     = 8        // equal samples needed to accept a new clock level
) (
    input  logic       clock32,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // ------------------------------------------------------------------
    // Derived widths and terminal counts
    // ------------------------------------------------------------------
    localparam int HOLD_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int HW       = $clog2(HOLD_MAX + 1);
    localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [HW-1:0] INH_LAST  = HW'(INHIBIT_CYCLES - 1);
    localparam logic [HW-1:0] RTS_LAST  = HW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAITIDLE
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_s;
    logic          data_s;
    logic          clk_filt_q;
    logic [FW-1:0] filt_cnt_q;
    logic          fall_q;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Two-flop synchronisers for both pins; they idle high like the pulled-up bus.
    always_ff @(posedge clock32 or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    // Clock glitch filter: the level flips only after FILTER_LEN consecutive
    // samples disagree with it. A 1->0 flip raises `fall` for one cycle.
    always_ff @(posedge clock32 or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (clk_s == clk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                clk_filt_q <= clk_s;
                filt_cnt_q <= '0;
                fall_q     <= ~clk_s;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer state machine
    // ------------------------------------------------------------------
    state_t        state_q;
    logic [8:0]    shreg_q;       // {parity, data}; bit 0 is the next bit to present
    logic [3:0]    bitcnt_q;      // falls seen in SEND
    logic [HW-1:0] hold_cnt_q;    // INHIBIT / RTS duration
    logic [TW-1:0] to_cnt_q;      // cycles since clock release
    logic          clk_oe_q;
    logic          data_oe_q;
    logic          tx_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;

    logic par_d;
    logic accept;
    logic to_expire;

    assign par_d     = ~^tx_data;
    assign accept    = tx_valid & tx_ready_q;
    assign to_expire = (to_cnt_q == TO_LAST);

    // Sequences one byte through request-to-send, bit shifting, the device ACK
    // and the final bus-idle check. All outputs are registered here.
    always_ff @(posedge clock32 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            hold_cnt_q <= '0;
            to_cnt_q   <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (accept) begin
                        shreg_q    <= {par_d, tx_data};
                        hold_cnt_q <= '0;
                        clk_oe_q   <= 1'b1;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (hold_cnt_q == INH_LAST) begin
                        hold_cnt_q <= '0;
                        data_oe_q  <= 1'b1;    // start bit
                        state_q    <= S_RTS;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end

                S_RTS: begin
                    if (hold_cnt_q == RTS_LAST) begin
                        hold_cnt_q <= '0;
                        clk_oe_q   <= 1'b0;    // hand the clock to the device
                        bitcnt_q   <= '0;
                        to_cnt_q   <= '0;
                        state_q    <= S_SEND;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end

                S_SEND: begin
                    if (to_expire) begin
                        error_q    <= 1'b1;
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                        if (fall_q) begin
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd9) begin
                                // Tenth fall: release data so the line reads as the stop bit.
                                data_oe_q <= 1'b0;
                                state_q   <= S_ACK;
                            end else begin
                                // Falls 1-9 present d0..d7 then parity.
                                data_oe_q <= ~shreg_q[0];
                                shreg_q   <= {1'b0, shreg_q[8:1]};
                            end
                        end
                    end
                end

                S_ACK: begin
                    if (to_expire) begin
                        error_q    <= 1'b1;
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                        if (fall_q) begin
                            if (!data_s) begin
                                state_q <= S_WAITIDLE;
                            end else begin
                                // Device left data high on the ACK clock: NACK.
                                error_q    <= 1'b1;
                                tx_ready_q <= 1'b1;
                                busy_q     <= 1'b0;
                                state_q    <= S_IDLE;
                            end
                        end
                    end
                end

                S_WAITIDLE: begin
                    if (to_expire) begin
                        error_q    <= 1'b1;
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                        if (clk_filt_q && data_s) begin
                            done_q     <= 1'b1;
                            tx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end
                end

                default: begin
                    clk_oe_q   <= 1'b0;
                    data_oe_q  <= 1'b0;
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on a wired-AND bus.
// Timing parameters are scaled down so that the whole run stays short.
module tb_ps2_host_tx;

    localparam int INH  = 200;
    localparam int RTS  = 16;
    localparam int TO   = 6000;
    localparam int FL   = 8;
    localparam int HALF = 64;      // device clock half period in system cycles

    logic       clock32  = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, done, error, busy;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES(RTS),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN(FL)
    ) dut (
        .clock32(clock32),
        .reset_n(reset_n),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .done(done),
        .error(error),
        .busy(busy),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Open-drain bus with pull-ups: either side can pull a line low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clock32 = ~clock32;

    always @(posedge clock32) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
    end

    task automatic tick;
        @(posedge clock32);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a byte while idle; afterwards the clock must be pulled low.
    task automatic accept(input logic [7:0] d, input bit hold);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        check("acc_clk_oe", ps2_clk_oe, 1);
        check("acc_tx_ready", tx_ready, 0);
        check("acc_busy", busy, 1);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Measure the inhibit and request-to-send phases; ends at the clock release.
    task automatic measure;
        int n;
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 4 * INH) begin tick(); n++; end
        check("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && n < 4 * RTS) begin tick(); n++; end
        check("rts_len", n, RTS);
        check("release_start", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    // Device side of one frame: 11 clocks, sample on each rising edge.
    task automatic dev_frame(input int abort_at, input bit nack, input bit glitch,
                             output logic [9:0] rx);
        int d0, e0;
        rx = '0;
        repeat (20) tick();
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && !nack) dev_data = 1'b0;
            dev_clk = 1'b0;
            repeat (HALF) tick();
            if (i == abort_at) begin
                check("pre_reset_data_oe", ps2_data_oe, 1);
                d0 = done_cnt;
                e0 = err_cnt;
                #2 reset_n = 1'b0;
                #1;
                check("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
                check("rst_async_ready", {tx_ready, busy, done, error}, 4'b1000);
                dev_clk = 1'b1;
                repeat (3) tick();
                #2 reset_n = 1'b1;
                repeat (30) tick();
                check("rst_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'd0);
                return;
            end
            if (i <= 10) rx[i-1] = ps2_data_in;
            dev_clk = 1'b1;
            if (glitch && i <= 9) begin
                repeat (20) tick();
                dev_clk = 1'b0;
                repeat (3) tick();
                dev_clk = 1'b1;
                repeat (HALF - 23) tick();
            end else begin
                repeat (HALF) tick();
            end
        end
        repeat (10) tick();
        dev_data = 1'b1;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin tick(); n++; end
        check("done_seen", done, 1);
    endtask

    initial begin
        logic [9:0] rx;
        int d0, e0, n;

        // Reset state
        repeat (3) tick();
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("rst_pulses", {done, error}, 2'b00);
        #2 reset_n = 1'b1;
        repeat (20) tick();

        // Send ED: LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1
        d0 = done_cnt; e0 = err_cnt;
        accept(8'hED, 0);
        measure();
        dev_frame(0, 0, 0, rx);
        check("ed_bits", rx, 10'h3ED);
        wait_done();
        tick();
        check("ed_done_once", done_cnt - d0, 1);
        check("ed_no_error", err_cnt - e0, 0);
        check("ed_idle", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
        $display("tx ED rx=%03h", rx);
        repeat (10) tick();

        // 00 then 04 back-to-back with tx_valid held
        accept(8'h00, 1);
        tx_data = 8'h04;
        measure();
        dev_frame(0, 0, 0, rx);
        check("b00_bits", rx, 10'h300);
        $display("tx 00 rx=%03h", rx);
        wait_done();
        tick();
        check("b2b_inhibit", ps2_clk_oe, 1);
        check("b2b_not_ready", tx_ready, 0);
        tx_valid = 1'b0;
        measure();
        dev_frame(0, 0, 0, rx);
        check("b04_bits", rx, 10'h204);
        $display("tx 04 rx=%03h", rx);
        wait_done();
        repeat (10) tick();

        // Device never clocks: timeout exactly TO cycles after release
        d0 = done_cnt; e0 = err_cnt;
        accept(8'h55, 0);
        measure();
        n = 0;
        while (error !== 1'b1 && n < TO + 100) begin tick(); n++; end
        check("timeout_cycles", n, TO);
        check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        tick();
        check("timeout_ready", tx_ready, 1);
        check("timeout_no_done", done_cnt - d0, 0);
        check("timeout_err_once", err_cnt - e0, 1);
        $display("tx 55 timeout after %0d cycles", n);
        repeat (10) tick();

        // NACK on the 11th clock
        d0 = done_cnt; e0 = err_cnt;
        accept(8'h3C, 0);
        measure();
        dev_frame(0, 1, 0, rx);
        repeat (20) tick();
        check("nack_err", err_cnt - e0, 1);
        check("nack_no_done", done_cnt - d0, 0);
        check("nack_idle", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
        $display("tx 3C nack rx=%03h", rx);
        accept(8'h81, 0);
        measure();
        dev_frame(0, 0, 0, rx);
        check("after_nack_bits", rx, 10'h381);
        wait_done();
        $display("tx 81 rx=%03h", rx);
        repeat (10) tick();

        // Glitch rejection while sending A5
        d0 = done_cnt; e0 = err_cnt;
        accept(8'hA5, 0);
        measure();
        dev_frame(0, 0, 1, rx);
        check("glitch_bits", rx, 10'h3A5);
        wait_done();
        check("glitch_no_error", err_cnt - e0, 0);
        $display("tx A5 glitched rx=%03h", rx);
        repeat (10) tick();

        // Reset after the 4th fall of a 00 transfer (d3 = 0 keeps data pulled low)
        accept(8'h00, 0);
        measure();
        dev_frame(4, 0, 0, rx);
        check("post_reset_idle", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
        $display("tx 00 reset after fall 4");

        check("never_done_and_error", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
